// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice.
//   WIDTH        : datapath width (fixed at 16)
//   AMT_W        : shift-amount width, log2(WIDTH)
//   shift_mode_t : operation encoding carried on reqN_mode
package shift_pkg;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRA = 2'b01,
    SHIFT_ROR = 2'b10,
    SHIFT_ILL = 2'b11
  } shift_mode_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle between two requesters, the shift arbiter and the
// result consumer.
//   req_valid[1:0]  : requester i presents an operation
//   req_ready[1:0]  : requester i's operation is accepted this cycle
//   reqN_data/amt/mode : operand, shift amount and operation per requester
//   res_valid/res_ready : result handshake
//   res_data/res_id/res_err : shifted value, winning requester, illegal flag
// master : requester/consumer side; slave : arbiter side.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_data;
  logic [WIDTH-1:0] req1_data;
  logic [AMT_W-1:0] req0_amt;
  logic [AMT_W-1:0] req1_amt;
  logic [1:0]       req0_mode;
  logic [1:0]       req1_mode;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             res_err;

  modport master (
    output req_valid, req0_data, req1_data, req0_amt, req1_amt,
           req0_mode, req1_mode, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_err
  );

  modport slave (
    input  req_valid, req0_data, req1_data, req0_amt, req1_amt,
           req0_mode, req1_mode, res_ready,
    output req_ready, res_valid, res_data, res_id, res_err
  );

endinterface

// File: rtl/shift_unit.sv
// Combinational 16-bit shifter shared by both requesters.
//   data    : operand
//   amt     : shift amount, 0..15 (0 passes the operand through)
//   mode    : SLL (zero fill), SRA (sign fill), ROR (rotate right), ILL
//   result  : shifted value; operand unchanged for the illegal mode
//   illegal : high when mode is the illegal encoding
module shift_unit
  import shift_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  function automatic logic [WIDTH-1:0] sll_f(input logic [WIDTH-1:0] x,
                                             input logic [AMT_W-1:0] a);
    return x << a;
  endfunction

  function automatic logic [WIDTH-1:0] sra_f(input logic signed [WIDTH-1:0] x,
                                             input logic [AMT_W-1:0] a);
    logic signed [WIDTH-1:0] s;
    s = x >>> a;
    return s;
  endfunction

  // Rotating right is the low half of the doubled operand shifted right,
  // which also yields the operand itself for a zero amount.
  function automatic logic [WIDTH-1:0] ror_f(input logic [WIDTH-1:0] x,
                                             input logic [AMT_W-1:0] a);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} >> a;
    return dbl[WIDTH-1:0];
  endfunction

  always_comb begin
    result  = data;
    illegal = 1'b0;
    unique case (mode)
      SHIFT_SLL: result = sll_f(data, amt);
      SHIFT_SRA: result = sra_f(data, amt);
      SHIFT_ROR: result = ror_f(data, amt);
      SHIFT_ILL: illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared shift unit, with a single
// output result register returned over a valid/ready handshake.
//   clk    : clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : shift_arbiter_if.slave (request inputs, grants, result outputs)
// Parameters:
//   WIDTH  : data width, fixed at 16
//   AMT_W  : shift-amount width, 4
//   FAIR   : 1 = round-robin between contending requesters,
//            0 = requester 0 always wins when valid
module shift_arbiter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int FAIR  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus
);
  import shift_pkg::shift_mode_t;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             id_p1;
  logic             err_p1;
  logic             last;

  logic             slot_free;
  logic [1:0]       grant;
  logic             grant_any;
  logic             grant_idx;

  logic [WIDTH-1:0] op_data_p0;
  logic [AMT_W-1:0] op_amt_p0;
  shift_mode_t      op_mode_p0;
  logic [WIDTH-1:0] sh_res_p0;
  logic             sh_ill_p0;

  // Grants are withheld while reset is asserted so nothing can be accepted
  // that the held-in-reset register would then drop.
  always_comb begin
    slot_free = !vld_p1 || bus.res_ready;
    grant     = 2'b00;
    if (slot_free && rst_n) begin
      unique case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          if (FAIR != 0) grant = last ? 2'b01 : 2'b10;
          else           grant = 2'b01;
        end
        default: grant = 2'b00;
      endcase
    end
    grant_any = |grant;
    grant_idx = grant[1];
  end

  assign bus.req_ready = grant;

  // Stage p0: operand mux driven by the winner, into the shared shifter.
  always_comb begin
    if (grant_idx) begin
      op_data_p0 = bus.req1_data;
      op_amt_p0  = bus.req1_amt;
      op_mode_p0 = shift_mode_t'(bus.req1_mode);
    end else begin
      op_data_p0 = bus.req0_data;
      op_amt_p0  = bus.req0_amt;
      op_mode_p0 = shift_mode_t'(bus.req0_mode);
    end
  end

  shift_unit u_shift (
    .data    (op_data_p0),
    .amt     (op_amt_p0),
    .mode    (op_mode_p0),
    .result  (sh_res_p0),
    .illegal (sh_ill_p0)
  );

  // Stage p1: result register. A grant always overwrites (the slot is free
  // either because it was empty or because it is being consumed now); a
  // consume without a grant empties it; otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      id_p1   <= 1'b0;
      err_p1  <= 1'b0;
      last    <= 1'b1;
    end else if (grant_any) begin
      vld_p1  <= 1'b1;
      data_p1 <= sh_res_p0;
      id_p1   <= grant_idx;
      err_p1  <= sh_ill_p0;
      last    <= grant_idx;
    end else if (bus.res_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.res_valid = vld_p1;
  assign bus.res_data  = data_p1;
  assign bus.res_id    = id_p1;
  assign bus.res_err   = err_p1;

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_arbiter_if bus_a ();
  shift_arbiter_if bus_b ();

  // The fixed-priority instance sees exactly the same stimulus.
  assign bus_b.req_valid = bus_a.req_valid;
  assign bus_b.req0_data = bus_a.req0_data;
  assign bus_b.req1_data = bus_a.req1_data;
  assign bus_b.req0_amt  = bus_a.req0_amt;
  assign bus_b.req1_amt  = bus_a.req1_amt;
  assign bus_b.req0_mode = bus_a.req0_mode;
  assign bus_b.req1_mode = bus_a.req1_mode;
  assign bus_b.res_ready = bus_a.res_ready;

  shift_arbiter #(.WIDTH(16), .AMT_W(4), .FAIR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  shift_arbiter #(.WIDTH(16), .AMT_W(4), .FAIR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Reference state: what the result register should hold, and who won last.
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_id;
  logic        m_err;
  logic        m_last;

  typedef struct {
    logic [1:0]  v;
    logic [15:0] d0; logic [3:0] a0; logic [1:0] m0;
    logic [15:0] d1; logic [3:0] a1; logic [1:0] m1;
    logic [15:0] ed; logic eid; logic eerr;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift behaviour from plain arithmetic: multiply, floor-divide, and
  // recombining quotient/remainder for the rotate. Bit 16 is the error flag.
  function automatic logic [16:0] ref_shift(input logic [15:0] x, input logic [3:0] a,
                                            input logic [1:0] m);
    int unsigned p, ux;
    int sx, q;
    p  = 32'd1 << a;
    ux = 32'(x);
    case (m)
      2'd0: return {1'b0, 16'((ux * p) % 32'd65536)};
      2'd1: begin
        sx = x[15] ? int'(ux) - 65536 : int'(ux);
        if (sx < 0) q = (sx - int'(p) + 1) / int'(p);
        else        q = sx / int'(p);
        return {1'b0, 16'(q)};
      end
      2'd2: return {1'b0, 16'((ux / p) + (ux % p) * (32'd65536 / p))};
      default: return {1'b1, x};
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 16'h0; m_id = 1'b0; m_err = 1'b0; m_last = 1'b1;
  endtask

  task automatic set_req(input logic [1:0] v,
                         input logic [15:0] d0, input logic [3:0] a0, input logic [1:0] m0,
                         input logic [15:0] d1, input logic [3:0] a1, input logic [1:0] m1,
                         input logic rr);
    bus_a.req_valid = v;
    bus_a.req0_data = d0; bus_a.req0_amt = a0; bus_a.req0_mode = m0;
    bus_a.req1_data = d1; bus_a.req1_amt = a1; bus_a.req1_mode = m1;
    bus_a.res_ready = rr;
  endtask

  // Called at a falling edge with inputs already driven: checks the grant,
  // advances the reference across the rising edge, checks the result.
  task automatic step();
    logic [1:0]  g;
    logic        sf, idx;
    logic [16:0] r;
    logic        n_valid, n_id, n_err, n_last;
    logic [15:0] n_data;
    #1;
    sf = !m_valid || bus_a.res_ready;
    g  = 2'b00;
    if (sf) begin
      if (bus_a.req_valid == 2'b11) g = m_last ? 2'b01 : 2'b10;
      else                          g = bus_a.req_valid;
    end
    chk("req_ready", 32'(bus_a.req_ready), 32'(g));
    n_valid = m_valid; n_data = m_data; n_id = m_id; n_err = m_err; n_last = m_last;
    if (g != 2'b00) begin
      idx = (g == 2'b10);
      r = idx ? ref_shift(bus_a.req1_data, bus_a.req1_amt, bus_a.req1_mode)
              : ref_shift(bus_a.req0_data, bus_a.req0_amt, bus_a.req0_mode);
      n_valid = 1'b1; n_data = r[15:0]; n_err = r[16]; n_id = idx; n_last = idx;
    end else if (bus_a.res_ready) begin
      n_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_data = n_data; m_id = n_id; m_err = n_err; m_last = n_last;
    chk("res_valid", 32'(bus_a.res_valid), 32'(m_valid));
    chk("res_data",  32'(bus_a.res_data),  32'(m_data));
    chk("res_id",    32'(bus_a.res_id),    32'(m_id));
    chk("res_err",   32'(bus_a.res_err),   32'(m_err));
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{2'b01, 16'h0001, 4'd4,  2'd0, 16'h0000, 4'd0,  2'd0, 16'h0010, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 16'h0000, 4'd0,  2'd0, 16'h8000, 4'd15, 2'd1, 16'hFFFF, 1'b1, 1'b0};
    tbl[2] = '{2'b10, 16'h0000, 4'd0,  2'd0, 16'h0001, 4'd1,  2'd2, 16'h8000, 1'b1, 1'b0};
    tbl[3] = '{2'b10, 16'h0000, 4'd0,  2'd0, 16'h1234, 4'd0,  2'd2, 16'h1234, 1'b1, 1'b0};
    tbl[4] = '{2'b01, 16'hABCD, 4'd5,  2'd3, 16'h0000, 4'd0,  2'd0, 16'hABCD, 1'b0, 1'b1};
    tbl[5] = '{2'b01, 16'hF00F, 4'd4,  2'd0, 16'h0000, 4'd0,  2'd0, 16'h00F0, 1'b0, 1'b0};
    tbl[6] = '{2'b01, 16'h8001, 4'd0,  2'd1, 16'h0000, 4'd0,  2'd0, 16'h8001, 1'b0, 1'b0};
    tbl[7] = '{2'b10, 16'h0000, 4'd0,  2'd0, 16'h7000, 4'd12, 2'd1, 16'h0007, 1'b1, 1'b0};
    tbl[8] = '{2'b01, 16'h1234, 4'd4,  2'd2, 16'h0000, 4'd0,  2'd0, 16'h4123, 1'b0, 1'b0};
    tbl[9] = '{2'b10, 16'h0000, 4'd0,  2'd0, 16'h8000, 4'd4,  2'd1, 16'hF800, 1'b1, 1'b0};

    set_req(2'b00, 16'h0, 4'd0, 2'd0, 16'h0, 4'd0, 2'd0, 1'b0);
    model_reset();

    // Reset state, with requests pending.
    #12;
    set_req(2'b11, 16'h1111, 4'd1, 2'd0, 16'h2222, 4'd1, 2'd0, 1'b1);
    #1;
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    chk("rst_res_valid", 32'(bus_a.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus_a.res_data),  32'd0);
    chk("rst_res_id",    32'(bus_a.res_id),    32'd0);
    chk("rst_res_err",   32'(bus_a.res_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous contention: round-robin alternates starting at 0,
    // fixed priority stays on 0.
    for (int i = 0; i < 6; i++) begin
      set_req(2'b11, 16'h0003, 4'd1, 2'd0, 16'h0030, 4'd2, 2'd0, 1'b1);
      step();
      chk("rr_id",    32'(bus_a.res_id),    32'(i % 2));
      chk("rr_valid", 32'(bus_a.res_valid), 32'd1);
      chk("fp_id",    32'(bus_b.res_id),    32'd0);
      chk("fp_valid", 32'(bus_b.res_valid), 32'd1);
    end

    // Directed vectors, one requester at a time.
    for (int i = 0; i < 10; i++) begin
      set_req(tbl[i].v, tbl[i].d0, tbl[i].a0, tbl[i].m0,
              tbl[i].d1, tbl[i].a1, tbl[i].m1, 1'b1);
      step();
      chk($sformatf("tbl%0d_data", i), 32'(bus_a.res_data), 32'(tbl[i].ed));
      chk($sformatf("tbl%0d_id", i),   32'(bus_a.res_id),   32'(tbl[i].eid));
      chk($sformatf("tbl%0d_err", i),  32'(bus_a.res_err),  32'(tbl[i].eerr));
    end

    // Drain.
    set_req(2'b00, 16'h0, 4'd0, 2'd0, 16'h0, 4'd0, 2'd0, 1'b1);
    step();
    chk("drain_valid", 32'(bus_a.res_valid), 32'd0);

    // Stall for three cycles with both requesters waiting, then resume.
    set_req(2'b01, 16'h00FF, 4'd4, 2'd0, 16'h00F0, 4'd4, 2'd2, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      set_req(2'b11, 16'h00FF, 4'd4, 2'd0, 16'h00F0, 4'd4, 2'd2, 1'b0);
      #1;
      chk("stall_ready", 32'(bus_a.req_ready), 32'd0);
      step();
      chk("stall_data",  32'(bus_a.res_data),  32'h0FF0);
      chk("stall_id",    32'(bus_a.res_id),    32'd0);
      chk("stall_valid", 32'(bus_a.res_valid), 32'd1);
    end
    set_req(2'b11, 16'h00FF, 4'd4, 2'd0, 16'h00F0, 4'd4, 2'd2, 1'b1);
    #1;
    chk("resume_ready", 32'(bus_a.req_ready), 32'd2);
    step();
    chk("resume_data",  32'(bus_a.res_data),  32'h000F);
    chk("resume_id",    32'(bus_a.res_id),    32'd1);
    chk("resume_valid", 32'(bus_a.res_valid), 32'd1);

    // Randomized traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      set_req(2'($urandom_range(0, 3)),
              16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 7));
      step();
    end

    // Reset with a held result and requests pending.
    set_req(2'b01, 16'h1111, 4'd1, 2'd0, 16'h0, 4'd0, 2'd0, 1'b0);
    step();
    chk("pre_rst_valid", 32'(bus_a.res_valid), 32'd1);
    set_req(2'b11, 16'h0005, 4'd1, 2'd0, 16'h0050, 4'd1, 2'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus_a.res_valid), 32'd0);
    chk("midrst_ready", 32'(bus_a.req_ready), 32'd0);
    chk("midrst_data",  32'(bus_a.res_data),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(2'b11, 16'h0005, 4'd1, 2'd0, 16'h0050, 4'd1, 2'd0, 1'b1);
    step();
    chk("postrst_id",   32'(bus_a.res_id),   32'd0);
    chk("postrst_data", 32'(bus_a.res_data), 32'h000A);
    step();
    chk("postrst_id2",  32'(bus_a.res_id),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one combinational 16-bit shift unit between two requesters, such as the ALU issue path and the address-generation path. It arbitrates round-robin, captures the shift result in an output register, and returns it through a valid/ready handshake tagged with the winner's ID. The block sits between the decode/issue logic and writeback, replacing the per-requester shifter instances.

## Interface
Parameters:
- WIDTH, 16, data width; fixed at 16, do not override
- AMT_W, 4, shift-amount width, equal to log2(WIDTH)
- FAIR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority with requester 0 winning

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  2  bit i set means requester i presents an operation
- req_ready  out  2  bit i set means requester i's operation is accepted this cycle
- req0_data, req1_data  in  WIDTH  operand for each requester
- req0_amt, req1_amt  in  AMT_W  shift amount, 0..15
- req0_mode, req1_mode  in  2  operation: 00 SLL, 01 SRA, 10 ROR, 11 illegal
- res_valid  out  1  result register holds an unconsumed result
- res_ready  in  1  consumer accepts the result
- res_data  out  WIDTH  shifted result
- res_id  out  1  index of the requester that produced the result
- res_err  out  1  the operation was illegal (mode 11)

## Operation
- Slot free: `slot_free = !res_valid || res_ready`.
- Grant rule: at most one bit of `req_ready` is high. `req_ready[i]` is high only when `slot_free && req_valid[i]` and requester i wins arbitration.
- `req_ready` may depend combinationally on `req_valid` and `res_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Round-robin (FAIR=1):
  - Pointer `last` holds the index of the most recent grant.
  - When both requesters are valid, the grant goes to `!last`.
  - When only one is valid, that one wins.
  - `last` updates only on an actual grant.
- Fixed priority (FAIR=0): requester 0 wins whenever it is valid.
- Shift unit behaviour:
  - SLL: zero fill.
  - SRA: sign fill from bit 15.
  - ROR: `{x[amt-1:0], x[15:amt]}`.
  - Amount 0 passes the operand through unchanged for all three operations.
- Illegal mode 11: the operation is still granted and completes. `res_data` equals the operand unchanged and `res_err` = 1.
- On a grant, the next edge loads `res_data`, `res_id` and `res_err` and sets `res_valid`.
- If `res_ready && res_valid` and there is no grant, the next edge clears `res_valid`.
- The result register has two states:
  - EMPTY → FULL on a grant.
  - FULL → FULL on a grant accepted in the same cycle as the current result is consumed; the register is overwritten.
  - FULL → EMPTY on consume with no grant.
  - FULL holds its contents while `res_ready` = 0.

## Timing
- Reset values (asserted asynchronously while rst_n = 0):
  - `res_valid` = 0, `res_data` = 0, `res_id` = 0, `res_err` = 0.
  - `last` = 1, so requester 0 wins first.
  - `req_ready` = 0 while rst_n is low.
- Latency: an operation granted in cycle N produces `res_valid` = 1 in cycle N+1.
- Throughput: one operation per cycle while `res_ready` = 1.
- Stall: while `res_valid && !res_ready`, `req_ready` = 00 and all outputs are held stable.
- Back-to-back: consume and grant in the same cycle are allowed with no bubble.
- Reset mid-operation: any held result is discarded and no grant is issued. Requesters must re-present their operations after reset is released.
- A requester whose `req_valid` drops before a grant loses nothing; nothing is recorded for it.

## Structure
- Package `shift_pkg`:
  - `WIDTH` and `AMT_W` constants.
  - `shift_mode_t` enum: SHIFT_SLL = 2'b00, SHIFT_SRA = 2'b01, SHIFT_ROR = 2'b10, SHIFT_ILL = 2'b11.
- Sub-module `shift_unit`: purely combinational. Inputs: data, amount, mode. Outputs: result and illegal flag. It is instantiated once, fed by the operand mux selected by the grant.
- Top level contains the arbiter, the `last` pointer, the operand mux and the result register.

## Test plan
- Requester 0 only, SLL 0x0001 by 4, `res_ready` = 1 → next cycle `res_valid` = 1, `res_data` = 0x0010, `res_id` = 0, `res_err` = 0.
- Requester 1, SRA 0x8000 by 15 → `res_data` = 0xFFFF. Requester 1, ROR 0x0001 by 1 → 0x8000. ROR 0x1234 by 0 → 0x1234.
- Both requesters valid continuously, `res_ready` = 1, FAIR = 1 → `res_id` sequence 0,1,0,1,… with one result per cycle. Same stimulus with FAIR = 0 → all 0.
- Hold `res_ready` = 0 for 3 cycles with a result held → `req_ready` = 00 and `res_data`/`res_id` unchanged. When `res_ready` rises, a grant occurs in the same cycle and the new result appears the next cycle with no bubble.
- Mode 11 with operand 0xABCD → `res_data` = 0xABCD, `res_err` = 1. The next legal operation clears `res_err`.
- Assert rst_n low with a FULL result and requests pending → `res_valid` drops immediately. After release, the first contested grant goes to requester 0.
